// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master unified memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic master_idx_t;

  localparam master_idx_t M_CPU = 1'b0;
  localparam master_idx_t M_AUX = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational grant selection between the CPU and the auxiliary master.
module arb_pick2
  import mem_arb_pkg::*;
#(
  parameter int MAX_HOLD    = 8,
  parameter int ROUND_ROBIN = 1,
  parameter int HW          = 4
) (
  input  logic        i_req0,
  input  logic        i_req1,
  input  arb_state_t  i_state,
  input  master_idx_t i_last,
  input  logic [HW-1:0] i_hold,
  output logic        o_gnt0,
  output logic        o_gnt1
);

  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic w_below;
  assign w_below = (i_hold < HOLD_MAX);

  // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    case (i_state)
      LOCK0: begin
        if (i_req0 && (w_below || !i_req1)) o_gnt0 = 1'b1;
        else if (i_req1)                    o_gnt1 = 1'b1;
      end
      LOCK1: begin
        if (i_req1 && (w_below || !i_req0)) o_gnt1 = 1'b1;
        else if (i_req0)                    o_gnt0 = 1'b1;
      end
      default: begin
        if (i_req0 && i_req1) begin
          if (ROUND_ROBIN != 0 && i_last == M_CPU) o_gnt1 = 1'b1;
          else                                     o_gnt0 = 1'b1;
        end else begin
          o_gnt0 = i_req0;
          o_gnt1 = i_req1;
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the unified instruction/data memory: zero-cycle grant,
// bounded locked bursts and a one-cycle registered read return per master.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_HOLD    = 8,
  parameter int ROUND_ROBIN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wd,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rd,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wd,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int            HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  arb_state_t    r_state, w_state_nxt;
  master_idx_t   r_last;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wd;
  logic          r_m0_rvalid, r_m1_rvalid;
  logic [DW-1:0] r_m0_rd, r_m1_rd;

  logic          w_gnt0, w_gnt1, w_any;
  master_idx_t   w_sel;
  logic          w_we, w_lock, w_other_req;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_wd;

  arb_pick2 #(
    .MAX_HOLD    (MAX_HOLD),
    .ROUND_ROBIN (ROUND_ROBIN),
    .HW          (HW)
  ) u_pick (
    .i_req0  (m0_req),
    .i_req1  (m1_req),
    .i_state (r_state),
    .i_last  (r_last),
    .i_hold  (r_hold),
    .o_gnt0  (w_gnt0),
    .o_gnt1  (w_gnt1)
  );

  assign w_any       = w_gnt0 | w_gnt1;
  assign w_sel       = w_gnt1 ? M_AUX : M_CPU;
  assign w_we        = w_sel ? m1_we   : m0_we;
  assign w_lock      = w_sel ? m1_lock : m0_lock;
  assign w_adr       = w_sel ? m1_adr  : m0_adr;
  assign w_wd        = w_sel ? m1_wd   : m0_wd;
  assign w_other_req = w_sel ? m0_req  : m1_req;

  // Outputs are gated by reset so an access in flight is killed without waiting for an edge.
  assign m0_gnt    = w_gnt0 & reset;
  assign m1_gnt    = w_gnt1 & reset;
  assign mem_we    = w_any & w_we & reset;
  assign mem_adr   = !reset ? '0 : (w_any ? w_adr : r_adr);
  assign mem_wd    = !reset ? '0 : (w_any ? w_wd  : r_wd);
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rd     = r_m0_rd;
  assign m1_rd     = r_m1_rd;

  // The counter only survives while the same master keeps its lock; a preempting
  // owner never inherits it because its own lock state differs from r_state.
  always_comb begin
    w_state_nxt = IDLE;
    w_hold_nxt  = '0;
    if (w_any && w_lock) begin
      w_state_nxt = w_sel ? LOCK1 : LOCK0;
      if (r_state == w_state_nxt) w_hold_nxt = r_hold;
      if (w_other_req && w_hold_nxt != HOLD_MAX) w_hold_nxt = w_hold_nxt + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_last      <= M_AUX;
      r_hold      <= '0;
      r_adr       <= '0;
      r_wd        <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rd     <= '0;
      r_m1_rd     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_m0_rvalid <= w_gnt0 & ~m0_we;
      r_m1_rvalid <= w_gnt1 & ~m1_we;
      if (w_any) begin
        r_last <= w_sel;
        r_adr  <= w_adr;
        r_wd   <= w_wd;
      end
      if (w_gnt0 && !m0_we) r_m0_rd <= mem_rd;
      if (w_gnt1 && !m1_we) r_m1_rd <= mem_rd;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin reads, write/readback, lock bursts,
// fixed priority variant and reset in the middle of a write.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_adr, m0_wd, m1_adr, m1_wd;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rd, m1_rd, mem_adr, mem_wd, mem_rd;

  logic        fp_m0_req, fp_m1_req;
  logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_mem_we;
  logic [31:0] fp_m0_rd, fp_m1_rd, fp_mem_adr, fp_mem_wd;
  logic [31:0] fp_mem_rd = 32'h0;

  logic [31:0] tb_mem [0:255];
  logic        mem_loaded = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wd(m0_wd), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wd(m1_wd), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  mem_arbiter #(.ROUND_ROBIN(0)) u_fp (
    .clk(clk), .reset(reset),
    .m0_req(fp_m0_req), .m0_we(1'b0), .m0_adr(32'h10), .m0_wd(32'h0), .m0_lock(1'b0),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rd(fp_m0_rd),
    .m1_req(fp_m1_req), .m1_we(1'b0), .m1_adr(32'h20), .m1_wd(32'h0), .m1_lock(1'b0),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rd(fp_m1_rd),
    .mem_we(fp_mem_we), .mem_adr(fp_mem_adr), .mem_wd(fp_mem_wd), .mem_rd(fp_mem_rd)
  );

  assign mem_rd = tb_mem[mem_adr[7:0]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 32'h0;
      tb_mem[8'h10] <= 32'h1111_1111;
      tb_mem[8'h20] <= 32'h2222_2222;
      tb_mem[8'h80] <= 32'hCAFE_F00D;
      mem_loaded    <= 1'b1;
    end else if (mem_we) begin
      tb_mem[mem_adr[7:0]] <= mem_wd;
    end
  end

  task automatic drive0(input logic req, input logic we, input logic lock,
                        input logic [31:0] adr, input logic [31:0] wd);
    m0_req = req; m0_we = we; m0_lock = lock; m0_adr = adr; m0_wd = wd;
  endtask

  task automatic drive1(input logic req, input logic we, input logic lock,
                        input logic [31:0] adr, input logic [31:0] wd);
    m1_req = req; m1_we = we; m1_lock = lock; m1_adr = adr; m1_wd = wd;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fp_m0_req = 1'b0; fp_m1_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    n_vec++; if ({m0_rvalid, m1_rvalid, mem_we} !== 3'b000) begin n_err++; $display("FAIL reset_ctl: got %b want 000", {m0_rvalid, m1_rvalid, mem_we}); end
    n_vec++; if (mem_adr !== 32'h0 || mem_wd !== 32'h0) begin n_err++; $display("FAIL reset_mem: adr %h wd %h want 0 0", mem_adr, mem_wd); end
    n_vec++; if (m0_rd !== 32'h0 || m1_rd !== 32'h0) begin n_err++; $display("FAIL reset_rd: m0 %h m1 %h want 0 0", m0_rd, m1_rd); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_rr_reads();
    @(negedge clk);
    drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    drive1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    n_vec++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_err++; $display("FAIL rr_c0_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    n_vec++; if (mem_adr !== 32'h10 || mem_we !== 1'b0) begin n_err++; $display("FAIL rr_c0_mem: adr %h we %b want 10 0", mem_adr, mem_we); end
    @(negedge clk); #1;
    n_vec++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_err++; $display("FAIL rr_c1_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
    n_vec++; if (mem_adr !== 32'h20) begin n_err++; $display("FAIL rr_c1_adr: got %h want 20", mem_adr); end
    n_vec++; if (m0_rvalid !== 1'b1 || m0_rd !== 32'h1111_1111) begin n_err++; $display("FAIL rr_c1_m0rd: rvalid %b rd %h want 1 11111111", m0_rvalid, m0_rd); end
    n_vec++; if (m1_rvalid !== 1'b0) begin n_err++; $display("FAIL rr_c1_m1rv: got %b want 0", m1_rvalid); end
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    n_vec++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_err++; $display("FAIL rr_c2_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    n_vec++; if (m1_rvalid !== 1'b1 || m1_rd !== 32'h2222_2222) begin n_err++; $display("FAIL rr_c2_m1rd: rvalid %b rd %h want 1 22222222", m1_rvalid, m1_rd); end
    n_vec++; if (m0_rvalid !== 1'b0) begin n_err++; $display("FAIL rr_c2_m0rv: got %b want 0", m0_rvalid); end
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    n_vec++; if ({m0_gnt, m1_gnt, mem_we} !== 3'b000) begin n_err++; $display("FAIL rr_c3_idle: got %b want 000", {m0_gnt, m1_gnt, mem_we}); end
    n_vec++; if (mem_adr !== 32'h10) begin n_err++; $display("FAIL rr_c3_hold_adr: got %h want 10", mem_adr); end
    n_vec++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_err++; $display("FAIL rr_c3_rv: got %b want 10", {m0_rvalid, m1_rvalid}); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive1(1'b1, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
    #1;
    n_vec++; if ({m0_gnt, m1_gnt, mem_we} !== 3'b011) begin n_err++; $display("FAIL wr_gnt_we: got %b want 011", {m0_gnt, m1_gnt, mem_we}); end
    n_vec++; if (mem_adr !== 32'h40 || mem_wd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_bus: adr %h wd %h want 40 deadbeef", mem_adr, mem_wd); end
    @(negedge clk);
    m1_we = 1'b0;
    #1;
    n_vec++; if (tb_mem[8'h40] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_commit: got %h want deadbeef", tb_mem[8'h40]); end
    n_vec++; if ({m1_gnt, mem_we, m1_rvalid} !== 3'b100) begin n_err++; $display("FAIL rd_issue: got %b want 100", {m1_gnt, mem_we, m1_rvalid}); end
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    n_vec++; if (m1_rvalid !== 1'b1 || m1_rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_back: rvalid %b rd %h want 1 deadbeef", m1_rvalid, m1_rd); end
    @(negedge clk); #1;
    n_vec++; if (m1_rvalid !== 1'b0 || m1_rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_pulse_hold: rvalid %b rd %h want 0 deadbeef", m1_rvalid, m1_rd); end
  endtask

  task automatic test_lock_hold();
    @(negedge clk);
    drive0(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    drive1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_vec++; if ((m0_gnt & m1_gnt) !== 1'b0) begin n_err++; $display("FAIL lock_onehot c%0d: both gnt high", c); end
      n_vec++;
      if (c == 8) begin
        if ({m0_gnt, m1_gnt} !== 2'b01) begin n_err++; $display("FAIL lock_release c%0d: got %b want 01", c, {m0_gnt, m1_gnt}); end
      end else begin
        if ({m0_gnt, m1_gnt} !== 2'b10) begin n_err++; $display("FAIL lock_own c%0d: got %b want 10", c, {m0_gnt, m1_gnt}); end
      end
    end
    @(negedge clk);
    drive0(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    n_vec++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_err++; $display("FAIL lock_noreq: got %b want 00", {m0_gnt, m1_gnt}); end
  endtask

  task automatic test_lock_idle();
    @(negedge clk);
    drive0(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_vec++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_err++; $display("FAIL lock_idle c%0d: got %b want 10", c, {m0_gnt, m1_gnt}); end
    end
    @(negedge clk);
    drive1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    n_vec++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_err++; $display("FAIL lock_idle_nohold: got %b want 10", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    drive0(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    n_vec++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_err++; $display("FAIL lock_handover: got %b want 01", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_fixed_prio();
    @(negedge clk);
    fp_m0_req = 1'b1; fp_m1_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_vec++; if ({fp_m0_gnt, fp_m1_gnt} !== 2'b10) begin n_err++; $display("FAIL fixed_prio c%0d: got %b want 10", c, {fp_m0_gnt, fp_m1_gnt}); end
    end
    @(negedge clk);
    fp_m0_req = 1'b0; fp_m1_req = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    drive1(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    #1;
    n_vec++; if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL rmw_lock1: got %b want 1", m1_gnt); end
    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    drive0(1'b1, 1'b1, 1'b0, 32'h80, 32'h0000_1234);
    #1;
    n_vec++; if ({m0_gnt, mem_we, m1_rvalid} !== 3'b111) begin n_err++; $display("FAIL rmw_pre: got %b want 111", {m0_gnt, mem_we, m1_rvalid}); end
    #1;
    reset = 1'b0;
    #1;
    n_vec++; if ({m0_gnt, m1_gnt, mem_we} !== 3'b000) begin n_err++; $display("FAIL rmw_async: got %b want 000", {m0_gnt, m1_gnt, mem_we}); end
    n_vec++; if ({m0_rvalid, m1_rvalid} !== 2'b00 || m1_rd !== 32'h0) begin n_err++; $display("FAIL rmw_rv: rv %b m1_rd %h want 00 0", {m0_rvalid, m1_rvalid}, m1_rd); end
    n_vec++; if (mem_adr !== 32'h0 || mem_wd !== 32'h0) begin n_err++; $display("FAIL rmw_bus: adr %h wd %h want 0 0", mem_adr, mem_wd); end
    repeat (2) @(negedge clk);
    drive0(1'b0, 1'b0, 1'b0, 32'h80, 32'h0);
    reset = 1'b1;
    #1;
    n_vec++; if (tb_mem[8'h80] !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rmw_nocommit: got %h want cafef00d", tb_mem[8'h80]); end
    @(negedge clk);
    drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    drive1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    n_vec++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_err++; $display("FAIL rmw_idle_after: got %b want 10", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_reads();
    test_write_read();
    test_lock_hold();
    test_lock_idle();
    test_fixed_prio();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
